// File: rtl/canny_pkg.sv
// Shared Canny pipeline types: transmitter FSM states, output geometry and a counter-width helper.
`ifndef IM_WIDTH
`define IM_WIDTH 10
`endif
`ifndef IM_HEIGHT
`define IM_HEIGHT 8
`endif

package canny_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

    // Three 3x3 stages each trim one pixel from every border.
    localparam int OUT_W = `IM_WIDTH - 6;
    localparam int OUT_H = `IM_HEIGHT - 6;

    // Bits needed to hold the value n (minimum 1).
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction

endpackage

// File: rtl/edge_stream_tx_if.sv
// Pixel input handshake plus framed output stream of the edge transmitter.
interface edge_stream_tx_if #(
    parameter int NBIT = 8
);
    logic [NBIT-1:0] i_pixel;
    logic            i_pixel_valid;
    logic            o_pixel_ready;
    logic [NBIT-1:0] o_tdata;
    logic            o_tvalid;
    logic            i_tready;
    logic            o_tuser;
    logic            o_tlast;

    modport slave (
        input  i_pixel, i_pixel_valid, i_tready,
        output o_pixel_ready, o_tdata, o_tvalid, o_tuser, o_tlast
    );

    modport master (
        output i_pixel, i_pixel_valid, i_tready,
        input  o_pixel_ready, o_tdata, o_tvalid, o_tuser, o_tlast
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word; zero read latency, writes ignored when full.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module sync_fifo #(
    parameter int NBIT  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [NBIT-1:0] wr_dat,
    input  logic            rd_en,
    output logic [NBIT-1:0] rd_dat,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);

    logic [NBIT-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/edge_stream_tx.sv
// Buffers thresholded pixels and re-emits them as a framed raster (tuser=SOF, tlast=EOL); 2-cycle latency.
// Input ready depends only on state and FIFO fullness; a stalled output beat holds stable.
module edge_stream_tx
    import canny_pkg::*;
#(
    parameter int NBIT       = 8,
    parameter int OUT_WIDTH  = OUT_W,
    parameter int OUT_HEIGHT = OUT_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    edge_stream_tx_if.slave  bus,
    output logic             o_frame_done,
    output logic             o_busy
);
    localparam int TOTAL = OUT_WIDTH * OUT_HEIGHT;
    localparam int IN_W  = cnt_w(TOTAL);
    localparam int CW    = cnt_w(OUT_WIDTH - 1);
    localparam int RW    = cnt_w(OUT_HEIGHT - 1);

    tx_state_t       state, state_nxt;
    logic [IN_W-1:0] in_cnt;
    logic [CW-1:0]   col, ld_col;
    logic [RW-1:0]   row, ld_row;
    logic            pixel_ready;
    logic            fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [NBIT-1:0] fifo_dat;
    logic            out_vld, out_usr, out_lst;
    logic [NBIT-1:0] out_dat;
    logic            out_acc, start_acc, last_in;

    assign start_acc = (state == IDLE) && i_frame_start;
    assign fifo_wr   = bus.i_pixel_valid && pixel_ready;
    assign last_in   = fifo_wr && (in_cnt == IN_W'(TOTAL - 1));
    assign out_acc   = out_vld && bus.i_tready;
    assign fifo_rd   = !fifo_empty && (!out_vld || out_acc);

    sync_fifo #(.NBIT(NBIT), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .wr_en  (fifo_wr),
        .wr_dat (bus.i_pixel),
        .rd_en  (fifo_rd),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_frame_start) state_nxt = ACTIVE;
            ACTIVE:  if (last_in) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && (!out_vld || out_acc)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pixel_ready  = (state == ACTIVE) && !fifo_full;
        o_frame_done = (state == DONE);
        o_busy       = (state != IDLE);
    end

    // col/row track the beat in (or next into) the output register; the loaded
    // beat's position is the post-accept value so markers line up with the data.
    always_comb begin
        ld_col = col;
        ld_row = row;
        if (out_acc) begin
            if (col == CW'(OUT_WIDTH - 1)) begin
                ld_col = '0;
                ld_row = (row == RW'(OUT_HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
                ld_col = col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || start_acc) begin
            in_cnt <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            if (fifo_wr) in_cnt <= in_cnt + 1'b1;
            col <= ld_col;
            row <= ld_row;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_usr <= 1'b0;
            out_lst <= 1'b0;
        end else if (fifo_rd) begin
            out_vld <= 1'b1;
            out_dat <= fifo_dat;
            out_usr <= (ld_col == '0) && (ld_row == '0);
            out_lst <= (ld_col == CW'(OUT_WIDTH - 1));
        end else if (out_acc) begin
            out_vld <= 1'b0;
            out_usr <= 1'b0;
            out_lst <= 1'b0;
        end
    end

    assign bus.o_pixel_ready = pixel_ready;
    assign bus.o_tvalid      = out_vld;
    assign bus.o_tdata       = out_dat;
    assign bus.o_tuser       = out_usr;
    assign bus.o_tlast       = out_lst;
endmodule

// File: tb/tb_edge_stream_tx.sv
// Directed bench for edge_stream_tx with a 4x2 frame and a 4-deep FIFO.
module tb_edge_stream_tx;
    logic clk = 1'b0;
    logic rst_n;
    logic frame_start;
    logic frame_done;
    logic busy;

    edge_stream_tx_if #(.NBIT(8)) bus();

    edge_stream_tx #(
        .NBIT(8), .OUT_WIDTH(4), .OUT_HEIGHT(2), .FIFO_DEPTH(4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .bus           (bus),
        .o_frame_done  (frame_done),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int q0, d0;
    logic [7:0] q_dat[$];
    logic       q_usr[$];
    logic       q_lst[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are recorded mid-cycle; inputs are stable here, so tvalid&&tready means accept at next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.o_tvalid === 1'b1 && bus.i_tready === 1'b1) begin
                q_dat.push_back(bus.o_tdata);
                q_usr.push_back(bus.o_tuser);
                q_lst.push_back(bus.o_tlast);
                q_cyc.push_back(cyc);
            end
            if (frame_done === 1'b1) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        q0 = q_dat.size();
        d0 = done_cnt;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] px);
        logic ok, r;
        ok = 1'b0;
        bus.i_pixel = px;
        bus.i_pixel_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            r = bus.o_pixel_ready;
            step();
            ok = r;
        end
        chk($sformatf("feed_%0h", px), 32'(ok), 32'(1));
    endtask

    task automatic wait_done();
        for (int t = 0; t < 60 && done_cnt == d0; t++) step();
        step();
        step();
    endtask

    task automatic check_frame(input logic [7:0] base, input logic gaps);
        chk("beat_count", 32'(q_dat.size() - q0), 32'(8));
        for (int i = 0; i < 8; i++) begin
            if (q0 + i < q_dat.size()) begin
                chk($sformatf("data%0d", i), 32'(q_dat[q0+i]), 32'(base + 8'(i)));
                chk($sformatf("tuser%0d", i), 32'(q_usr[q0+i]), 32'(i == 0));
                chk($sformatf("tlast%0d", i), 32'(q_lst[q0+i]), 32'(i == 3 || i == 7));
                if (gaps && i > 0)
                    chk($sformatf("gap%0d", i), 32'(q_cyc[q0+i] - q_cyc[q0+i-1]), 32'(2));
            end
        end
        chk("done_pulses", 32'(done_cnt - d0), 32'(1));
        if (q_dat.size() >= q0 + 8)
            chk("done_timing", 32'(done_cyc), 32'(q_cyc[q0+7] + 1));
        chk("idle_after", 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        bus.i_pixel = '0;
        bus.i_pixel_valid = 1'b0;
        bus.i_tready = 1'b0;

        // Reset with random inputs
        for (int c = 0; c < 2; c++) begin
            bus.i_pixel = 8'($urandom);
            bus.i_pixel_valid = 1'($urandom);
            bus.i_tready = 1'($urandom);
            frame_start = 1'($urandom);
            step();
            chk("rst_flags", 32'({bus.o_pixel_ready, bus.o_tvalid, bus.o_tuser,
                                  bus.o_tlast, frame_done, busy}), 32'(0));
            chk("rst_tdata", 32'(bus.o_tdata), 32'(0));
        end
        frame_start = 1'b0;
        bus.i_pixel_valid = 1'b0;
        bus.i_tready = 1'b1;
        rst_n = 1'b1;
        step();

        // Nominal frame
        start_frame();
        chk("nom_busy", 32'(busy), 32'(1));
        chk("nom_ready", 32'(bus.o_pixel_ready), 32'(1));
        feed(8'h01);
        chk("lat_not_yet", 32'(bus.o_tvalid), 32'(0));
        feed(8'h02);
        chk("lat_valid", 32'(bus.o_tvalid), 32'(1));
        chk("lat_data", 32'(bus.o_tdata), 32'(8'h01));
        chk("lat_tuser", 32'(bus.o_tuser), 32'(1));
        for (int k = 3; k <= 8; k++) feed(8'(k));
        bus.i_pixel_valid = 1'b0;
        wait_done();
        check_frame(8'h01, 1'b0);

        // Backpressure: six edges with tready low while feeding
        bus.i_tready = 1'b0;
        start_frame();
        for (int k = 1; k <= 4; k++) feed(8'(k));
        chk("bp_ready_before_full", 32'(bus.o_pixel_ready), 32'(1));
        feed(8'h05);
        chk("bp_ready_full", 32'(bus.o_pixel_ready), 32'(0));
        chk("bp_tvalid", 32'(bus.o_tvalid), 32'(1));
        chk("bp_tdata", 32'(bus.o_tdata), 32'(8'h01));
        bus.i_pixel = 8'h06;
        step();
        chk("bp_ready_hold", 32'(bus.o_pixel_ready), 32'(0));
        chk("bp_tdata_hold", 32'(bus.o_tdata), 32'(8'h01));
        chk("bp_tuser_hold", 32'(bus.o_tuser), 32'(1));
        bus.i_tready = 1'b1;
        for (int k = 6; k <= 8; k++) feed(8'(k));
        bus.i_pixel_valid = 1'b0;
        wait_done();
        check_frame(8'h01, 1'b0);

        // Input gaps: valid alternates 1/0
        start_frame();
        for (int k = 1; k <= 8; k++) begin
            feed(8'(k));
            bus.i_pixel_valid = 1'b0;
            step();
        end
        wait_done();
        check_frame(8'h01, 1'b1);

        // Over-feed with 0x09 and a spurious start while ACTIVE
        start_frame();
        for (int k = 1; k <= 3; k++) feed(8'(k));
        frame_start = 1'b1;
        feed(8'h04);
        frame_start = 1'b0;
        for (int k = 5; k <= 8; k++) feed(8'(k));
        bus.i_pixel = 8'h09;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("over_ready%0d", c), 32'(bus.o_pixel_ready), 32'(0));
        end
        wait_done();
        bus.i_pixel_valid = 1'b0;
        check_frame(8'h01, 1'b0);

        // Mid-frame reset after three pixels, then a fresh frame
        start_frame();
        for (int k = 1; k <= 3; k++) feed(8'(k));
        bus.i_pixel_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_tvalid", 32'(bus.o_tvalid), 32'(0));
        rst_n = 1'b1;
        step();
        chk("mid_rst_idle_tvalid", 32'(bus.o_tvalid), 32'(0));
        start_frame();
        for (int k = 0; k < 8; k++) feed(8'hA1 + 8'(k));
        bus.i_pixel_valid = 1'b0;
        wait_done();
        check_frame(8'hA1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
